// File: rtl/src2_operand_decoder.sv
// Multi-cycle ARM data-processing Src2 decoder/shifter: one bit position per cycle.
// Optional macro SRC2_RRX_EN makes immediate-shift ROR #0 behave as RRX.
module src2_operand_decoder #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         i_bit,
    input  logic [11:0]  src2,
    input  logic [N-1:0] rm,
    input  logic [7:0]   rs_lo,
    input  logic         carry_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         carry_out
);

    localparam int CW = $clog2(N) + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    typedef enum logic [1:0] {OP_LSL, OP_LSR, OP_ASR, OP_ROR} shift_op_t;

    state_t         state;
    shift_op_t      op;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   opnd;
    logic           cy;
    logic           over;

    shift_op_t      dec_op;
    logic [CW-1:0]  dec_cnt;
    logic [N-1:0]   dec_opnd;
    logic           dec_carry;
    logic           dec_over;
`ifdef SRC2_RRX_EN
    logic           rrx;
    logic           dec_rrx;
`endif

    // NOTE: every signal gets a default before any branch so no latch is inferred.
    always_comb begin
        dec_opnd  = rm;
        dec_op    = shift_op_t'(src2[6:5]);
        dec_cnt   = '0;
        dec_carry = carry_in;
        dec_over  = 1'b0;
`ifdef SRC2_RRX_EN
        dec_rrx   = 1'b0;
`endif
        if (i_bit) begin
            dec_opnd = {{(N-8){1'b0}}, src2[7:0]};
            dec_op   = OP_ROR;
            dec_cnt  = CW'({src2[11:8], 1'b0});
        end else if (!src2[4]) begin
            dec_cnt = CW'(src2[11:7]);
            if (src2[11:7] == 5'd0) begin
                case (dec_op)
                    OP_LSR, OP_ASR: dec_cnt = CW'(N);
`ifdef SRC2_RRX_EN
                    OP_ROR: begin
                        dec_cnt = CW'(1);
                        dec_rrx = 1'b1;
                    end
`endif
                    default: ;
                endcase
            end
        end else if (rs_lo != 8'd0) begin
            if (dec_op == OP_ROR) begin
                dec_cnt = CW'(32'(rs_lo) % N);
                // A nonzero multiple of N rotates fully: value unchanged, carry is the top bit.
                if ((32'(rs_lo) % N) == 0)
                    dec_carry = rm[N-1];
            end else if (32'(rs_lo) > N) begin
                dec_cnt  = CW'(N);
                dec_over = 1'b1;
            end else begin
                dec_cnt = CW'(rs_lo);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            op        <= OP_LSL;
            cnt       <= '0;
            opnd      <= '0;
            cy        <= 1'b0;
            over      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
`ifdef SRC2_RRX_EN
            rrx       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        opnd  <= dec_opnd;
                        op    <= dec_op;
                        cnt   <= dec_cnt;
                        cy    <= dec_carry;
                        over  <= dec_over;
`ifdef SRC2_RRX_EN
                        rrx   <= dec_rrx;
`endif
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                        unique case (op)
                            OP_LSL: begin
                                cy   <= opnd[N-1];
                                opnd <= {opnd[N-2:0], 1'b0};
                            end
                            OP_LSR: begin
                                cy   <= opnd[0];
                                opnd <= {1'b0, opnd[N-1:1]};
                            end
                            OP_ASR: begin
                                cy   <= opnd[0];
                                opnd <= {opnd[N-1], opnd[N-1:1]};
                            end
                            OP_ROR: begin
                                cy <= opnd[0];
`ifdef SRC2_RRX_EN
                                opnd <= {(rrx ? cy : opnd[0]), opnd[N-1:1]};
`else
                                opnd <= {opnd[0], opnd[N-1:1]};
`endif
                            end
                        endcase
                    end else begin
                        result    <= opnd;
                        carry_out <= (over && (op == OP_LSL || op == OP_LSR)) ? 1'b0 : cy;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_src2_operand_decoder.sv
// Scoreboard bench for src2_operand_decoder: directed plan cases plus random operations
// checked against an arithmetic model of ARM Src2 shifter semantics.
module tb_src2_operand_decoder;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         i_bit = 1'b0;
    logic [11:0]  src2 = '0;
    logic [N-1:0] rm = '0;
    logic [7:0]   rs_lo = '0;
    logic         carry_in = 1'b0;
    logic         busy, done, carry_out;
    logic [N-1:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] res;
        logic        c;
        int          lat;
        time         t0;
    } exp_t;

    exp_t sb[$];

    src2_operand_decoder #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .i_bit(i_bit), .src2(src2),
        .rm(rm), .rs_lo(rs_lo), .carry_in(carry_in), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // ARM shifter semantics computed directly from the shift amount.
    function automatic exp_t model(input logic ib, input logic [11:0] s2, input logic [31:0] r,
                                   input logic [7:0] rs, input logic cin);
        exp_t e;
        int amt, rot, k;
        logic [1:0] typ;
        logic [31:0] v;
        e.t0 = 0;
        if (ib) begin
            rot = 2 * int'(s2[11:8]);
            v = {24'd0, s2[7:0]};
            k = rot;
            if (rot == 0) begin
                e.res = v; e.c = cin;
            end else begin
                e.res = (v >> rot) | (v << (32 - rot)); e.c = e.res[31];
            end
        end else begin
            typ = s2[6:5];
            if (s2[4]) amt = int'(rs);
            else begin
                amt = int'(s2[11:7]);
                if (amt == 0 && (typ == 2'd1 || typ == 2'd2)) amt = 32;
            end
            if (!s2[4] && amt == 0 && typ == 2'd3) begin
`ifdef SRC2_RRX_EN
                e.res = {cin, r[31:1]}; e.c = r[0]; k = 1;
`else
                e.res = r; e.c = cin; k = 0;
`endif
            end else if (amt == 0) begin
                e.res = r; e.c = cin; k = 0;
            end else begin
                k = (amt > 32) ? 32 : amt;
                case (typ)
                    2'd0: begin
                        e.res = (amt >= 32) ? 32'd0 : r << amt;
                        e.c = (amt > 32) ? 1'b0 : r[32 - amt];
                    end
                    2'd1: begin
                        e.res = (amt >= 32) ? 32'd0 : r >> amt;
                        e.c = (amt > 32) ? 1'b0 : r[amt - 1];
                    end
                    2'd2: begin
                        e.res = (amt >= 32) ? {32{r[31]}} : 32'($signed(r) >>> amt);
                        e.c = (amt >= 32) ? r[31] : r[amt - 1];
                    end
                    default: begin
                        k = amt % 32;
                        if (k == 0) begin
                            e.res = r; e.c = r[31];
                        end else begin
                            e.res = (r >> k) | (r << (32 - k)); e.c = r[k - 1];
                        end
                    end
                endcase
            end
        end
        e.lat = k + 1;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset && done) begin
            check("busy_with_done", {63'd0, busy}, 64'd0);
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", {32'd0, result}, {32'd0, e.res});
                check("carry_out", {63'd0, carry_out}, {63'd0, e.c});
                check("latency", 64'(($time - 5 - e.t0) / 10), 64'(e.lat));
            end
        end
    end

    task automatic run_op(input logic ib, input logic [11:0] s2, input logic [31:0] r,
                          input logic [7:0] rs, input logic cin, input bit noise);
        exp_t e;
        bit seen;
        @(negedge clk);
        i_bit = ib; src2 = s2; rm = r; rs_lo = rs; carry_in = cin; start = 1'b1;
        @(posedge clk);
        e = model(ib, s2, r, rs, cin);
        e.t0 = $time;
        sb.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            start = noise && ($urandom_range(0, 3) == 0);
            i_bit = 1'($urandom); src2 = 12'($urandom); rm = $urandom;
            rs_lo = 8'($urandom); carry_in = 1'($urandom);
            if (done) seen = 1'b1;
        end
        check("done_timeout", {63'd0, seen}, 64'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        logic [7:0] rs_pick [6];
        rs_pick = '{8'd0, 8'd31, 8'd32, 8'd33, 8'd64, 8'd255};

        repeat (2) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_result", {32'd0, result}, 64'd0);
        check("reset_carry", {63'd0, carry_out}, 64'd0);
        reset = 1'b1;

        run_op(1'b1, 12'h4FF, 32'h0, 8'd0, 1'b0, 1'b0);
        run_op(1'b0, 12'h200, 32'h8000000F, 8'd0, 1'b1, 1'b0);
        run_op(1'b0, 12'h040, 32'h80000000, 8'd0, 1'b0, 1'b0);
        run_op(1'b0, 12'h030, 32'hFFFFFFFF, 8'd40, 1'b0, 1'b0);
        run_op(1'b0, 12'h030, 32'hFFFFFFFF, 8'd0, 1'b1, 1'b0);
        run_op(1'b0, 12'h060, 32'h00000001, 8'd0, 1'b1, 1'b0);
        run_op(1'b0, 12'h070, 32'h80000001, 8'd64, 1'b0, 1'b0);
        run_op(1'b0, 12'h010, 32'h12345679, 8'd32, 1'b0, 1'b0);
        run_op(1'b0, 12'hA00, 32'h00000FFF, 8'd0, 1'b0, 1'b1);

        for (int n = 0; n < 150; n++) begin
            logic [7:0] rs;
            rs = ($urandom_range(0, 1) == 0) ? rs_pick[$urandom_range(0, 5)] : 8'($urandom);
            run_op(1'($urandom), 12'($urandom), $urandom, rs, 1'($urandom), 1'($urandom));
        end

        // Mid-operation reset: no done pulse may follow and outputs return to zero.
        @(negedge clk);
        i_bit = 1'b0; src2 = 12'hA00; rm = 32'hFFFFFFFF; carry_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_result", {32'd0, result}, 64'd0);
        check("abort_carry", {63'd0, carry_out}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (30) @(negedge clk);
        check("leftover_expectations", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
